tone_sequencer: RTL and testbench

Parametrised, triggerable successor to the fixed-song audio player. Holds a ROM of PROG_COUNT tone programs (note lists of half-period and duration), plays one on demand, and drives a 1-bit square-wave AUDIO pin. Game logic (ball hit, brick break, life lost) pulses START with a program index. BUSY and DONE status return to the game FSM.

---
 rtl/tone_seq_pkg.sv | 43 ++++
 rtl/tone_osc.sv | 48 ++++
 rtl/tone_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_tone_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_seq_pkg.sv
// Shared types and frame helpers for the triggerable tone sequencer.
// A frame word is {period, dur}; period=0/dur=0 marks the end of a program.
package tone_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      PLAY = 2'd2
   } state_e;

   localparam int unsigned DEF_PERIOD_W = 16;
   localparam int unsigned DEF_DUR_W    = 10;

   // Period field: the upper per_w bits above the dur_w duration field.
   function automatic logic [31:0] frame_period(
      input logic [63:0] word,
      input int unsigned dur_w,
      input int unsigned per_w
   );
      return 32'((word >> dur_w) & ((64'd1 << per_w) - 64'd1));
   endfunction

   // Duration field: the low dur_w bits.
   function automatic logic [31:0] frame_dur(
      input logic [63:0] word,
      input int unsigned dur_w
   );
      return 32'(word & ((64'd1 << dur_w) - 64'd1));
   endfunction

   function automatic logic is_end_frame(
      input logic [31:0] per,
      input logic [31:0] dur
   );
      return (per == 32'd0) && (dur == 32'd0);
   endfunction

   // A tone with zero duration still plays for one sequencer tick.
   function automatic logic [31:0] eff_dur(input logic [31:0] dur);
      return (dur == 32'd0) ? 32'd1 : dur;
   endfunction

endpackage

// File: rtl/tone_osc.sv
// Square-wave oscillator: toggles audio every PERIOD synth ticks.
// Ports: CLK, RESET_N, tick (synth tick), period, clr (phase clear), en -> audio.
module tone_osc #(
   parameter int unsigned PERIOD_W = 16
) (
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic                tick,
   input  logic [PERIOD_W-1:0] period,
   input  logic                clr,
   input  logic                en,
   output logic                audio
);

   localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

   logic [PERIOD_W-1:0] phase_q, phase_d;
   logic                tog_q, tog_d;

   always_comb begin
      phase_d = phase_q;
      tog_d   = tog_q;
      if (clr || !en) begin
         phase_d = '0;
         tog_d   = 1'b0;
      end else if (tick) begin
         if (phase_q == period - ONE) begin
            phase_d = '0;
            tog_d   = ~tog_q;
         end else begin
            phase_d = phase_q + ONE;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         phase_q <= '0;
         tog_q   <= 1'b0;
      end else begin
         phase_q <= phase_d;
         tog_q   <= tog_d;
      end
   end

   assign audio = tog_q;

endmodule

// File: rtl/tone_sequencer.sv
// Plays one of PROG_COUNT tone programs from a frame ROM on START; ABORT stops.
// Ports: CLK, RESET_N, START, PROG_SEL, ABORT -> BUSY, DONE, AUDIO.
// ROM images come in as FRAME_INIT ({period,dur} words) and PROG_INIT
// (start address per program). Define TONE_SEQ_PRIORITY_EN so that a START
// during PLAY preempts only when PROG_SEL exceeds the running program index.
module tone_sequencer
   import tone_seq_pkg::*;
#(
   parameter int unsigned FRAME_COUNT = 64,
   parameter int unsigned PROG_COUNT  = 4,
   parameter int unsigned PERIOD_W    = DEF_PERIOD_W,
   parameter int unsigned DUR_W       = DEF_DUR_W,
   parameter int unsigned SEQ_DIV     = 48828,
   parameter int unsigned SYNTH_DIV   = 128,
   parameter logic [PERIOD_W+DUR_W-1:0] FRAME_INIT [FRAME_COUNT] =
      '{default: '0},
   parameter logic [$clog2(FRAME_COUNT)-1:0] PROG_INIT [PROG_COUNT] =
      '{default: '0}
) (
   input  logic                          CLK,
   input  logic                          RESET_N,
   input  logic                          START,
   input  logic [$clog2(PROG_COUNT)-1:0] PROG_SEL,
   input  logic                          ABORT,
   output logic                          BUSY,
   output logic                          DONE,
   output logic                          AUDIO
);

   localparam int AW  = $clog2(FRAME_COUNT);
   localparam int SQW = $clog2(SEQ_DIV);
   localparam int SYW = $clog2(SYNTH_DIV);
   localparam int FW  = PERIOD_W + DUR_W;

   localparam logic [SQW-1:0] SEQ_LAST = SQW'(SEQ_DIV - 1);
   localparam logic [SYW-1:0] SYN_LAST = SYW'(SYNTH_DIV - 1);
   localparam logic [AW-1:0]  ADDR_TOP = AW'(FRAME_COUNT - 1);

   state_e              state_q, state_d;
   logic [AW-1:0]       addr_q, addr_d;
   logic [PERIOD_W-1:0] per_q, per_d;
   logic [DUR_W-1:0]    dur_q, dur_d;
   logic [DUR_W-1:0]    dcnt_q, dcnt_d;
   logic [SQW-1:0]      seq_q, seq_d;
   logic [SYW-1:0]      syn_q, syn_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [FW-1:0]       rd_word;
   logic [PERIOD_W-1:0] rd_per;
   logic [DUR_W-1:0]    rd_dur;
   logic [DUR_W-1:0]    dur_last;
   logic                seq_tick, syn_tick;
   logic                sel_ok, preempt_ok;
   logic                osc_clr, osc_en;

   assign rd_word  = FRAME_INIT[addr_q];
   assign rd_per   = PERIOD_W'(frame_period(64'(rd_word), DUR_W, PERIOD_W));
   assign rd_dur   = DUR_W'(frame_dur(64'(rd_word), DUR_W));
   assign dur_last = DUR_W'(eff_dur(32'(dur_q)) - 32'd1);
   assign seq_tick = (seq_q == SEQ_LAST);
   assign syn_tick = (syn_q == SYN_LAST);
   assign sel_ok   = START && (32'(PROG_SEL) < PROG_COUNT);

`ifdef TONE_SEQ_PRIORITY_EN
   logic [$clog2(PROG_COUNT)-1:0] cur_q, cur_d;

   assign preempt_ok = (PROG_SEL > cur_q);

   always_comb begin
      cur_d = cur_q;
      if (!ABORT && sel_ok) begin
         if (state_q == IDLE || (state_q == PLAY && preempt_ok)) begin
            cur_d = PROG_SEL;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) cur_q <= '0;
      else          cur_q <= cur_d;
   end
`else
   assign preempt_ok = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      per_d   = per_q;
      dur_d   = dur_q;
      dcnt_d  = dcnt_q;
      seq_d   = seq_q;
      syn_d   = syn_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (sel_ok) begin
               state_d = LOAD;
               addr_d  = PROG_INIT[PROG_SEL];
            end
         end
         LOAD: begin
            per_d  = rd_per;
            dur_d  = rd_dur;
            dcnt_d = '0;
            seq_d  = '0;
            syn_d  = '0;
            if (is_end_frame(32'(rd_per), 32'(rd_dur))) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = PLAY;
            end
         end
         PLAY: begin
            seq_d = seq_tick ? '0 : seq_q + SQW'(1);
            syn_d = syn_tick ? '0 : syn_q + SYW'(1);
            if (sel_ok && preempt_ok) begin
               state_d = LOAD;
               addr_d  = PROG_INIT[PROG_SEL];
            end else if (seq_tick) begin
               // compare before increment: dcnt never passes dur-1
               if (dcnt_q == dur_last) begin
                  if (addr_q == ADDR_TOP) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = LOAD;
                     addr_d  = addr_q + AW'(1);
                  end
               end else begin
                  dcnt_d = dcnt_q + DUR_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (ABORT) begin
         state_d = IDLE;
         done_d  = 1'b0;
      end
   end

   assign busy_d = (state_d != IDLE);

   // Silence whenever not in PLAY or about to leave it, so audio is low
   // during LOAD, after an abort and when a note ends.
   assign osc_clr = (state_q != PLAY) || (state_d != PLAY);
   assign osc_en  = (per_q != '0);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= IDLE;
         addr_q  <= '0;
         per_q   <= '0;
         dur_q   <= '0;
         dcnt_q  <= '0;
         seq_q   <= '0;
         syn_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         per_q   <= per_d;
         dur_q   <= dur_d;
         dcnt_q  <= dcnt_d;
         seq_q   <= seq_d;
         syn_q   <= syn_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   tone_osc #(
      .PERIOD_W (PERIOD_W)
   ) u_osc (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .tick    (syn_tick),
      .period  (per_q),
      .clr     (osc_clr),
      .en      (osc_en),
      .audio   (AUDIO)
   );

   assign BUSY = busy_q;
   assign DONE = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer: expected {BUSY,DONE,AUDIO} change
// events are queued by stimulus and matched by a monitor on each change.
module tb_tone_sequencer;

   logic       CLK;
   logic       RESET_N;
   logic       START;
   logic [1:0] PROG_SEL;
   logic       ABORT;
   logic       BUSY;
   logic       DONE;
   logic       AUDIO;

   // frame word = (period << 10) | dur
   localparam logic [25:0] TB_FRAMES [64] = '{
      0:  26'h803,
      4:  26'h401,
      5:  26'h002,
      6:  26'h402,
      62: 26'h401,
      63: 26'h801,
      default: 26'h0
   };
   localparam logic [5:0] TB_PROGS [4] = '{6'd0, 6'd4, 6'd62, 6'd0};

   tone_sequencer #(
      .FRAME_COUNT (64),
      .PROG_COUNT  (4),
      .PERIOD_W    (16),
      .DUR_W       (10),
      .SEQ_DIV     (10),
      .SYNTH_DIV   (4),
      .FRAME_INIT  (TB_FRAMES),
      .PROG_INIT   (TB_PROGS)
   ) dut (
      .CLK      (CLK),
      .RESET_N  (RESET_N),
      .START    (START),
      .PROG_SEL (PROG_SEL),
      .ABORT    (ABORT),
      .BUSY     (BUSY),
      .DONE     (DONE),
      .AUDIO    (AUDIO)
   );

   typedef struct {
      int         cyc;
      logic [2:0] v;
   } ev_t;

   ev_t exp_q[$];
   int  cyc      = 0;
   int  checks   = 0;
   int  failures = 0;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic push(input int c, input logic [2:0] v);
      ev_t e;
      e.cyc = c;
      e.v   = v;
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input logic got, input logic want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%b want=%b", name, got, want);
      end
   endtask

   task automatic goto_cyc(input int t);
      while (cyc < t) begin
         @(negedge CLK);
         START = 1'b0;
         ABORT = 1'b0;
      end
   endtask

   task automatic pulse_start(input logic [1:0] sel, output int l);
      START    = 1'b1;
      PROG_SEL = sel;
      l        = cyc + 1;
   endtask

   // prog0 from LOAD cycle l, optionally without the LOAD event itself
   task automatic push_prog0(input int l, input bit with_load);
      if (with_load) push(l, 3'b100);
      push(l + 9,  3'b101);
      push(l + 17, 3'b100);
      push(l + 25, 3'b101);
      push(l + 31, 3'b100);
      push(l + 32, 3'b010);
      push(l + 33, 3'b000);
   endtask

   // prog1 events after its first tone: rest then second tone then end
   task automatic push_prog1_tail(input int l);
      push(l + 37, 3'b101);
      push(l + 41, 3'b100);
      push(l + 45, 3'b101);
      push(l + 49, 3'b100);
      push(l + 54, 3'b010);
      push(l + 55, 3'b000);
   endtask

   task automatic push_prog1_head(input int l);
      push(l,     3'b100);
      push(l + 5, 3'b101);
      push(l + 9, 3'b100);
   endtask

   initial begin : monitor
      logic [2:0] prev;
      logic [2:0] now;
      ev_t        e;
      prev = 3'b000;
      forever begin
         @(negedge CLK);
         now = {BUSY, DONE, AUDIO};
         if (now !== prev) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL evt_extra cyc=%0d got=%b want=none", cyc, now);
            end else begin
               e = exp_q.pop_front();
               if (e.cyc != cyc || e.v !== now) begin
                  failures++;
                  $display("FAIL evt got cyc=%0d val=%b want cyc=%0d val=%b",
                           cyc, now, e.cyc, e.v);
               end
            end
            prev = now;
         end
      end
   end

   initial begin : stim
      int l;
      int l2;
      int t;
      START    = 1'b0;
      ABORT    = 1'b0;
      PROG_SEL = 2'd0;
      RESET_N  = 1'b0;
      repeat (3) @(negedge CLK);
      #2 RESET_N = 1'b1;
      #1;
      check("rst_busy", BUSY, 1'b0);
      check("rst_done", DONE, 1'b0);
      check("rst_audio", AUDIO, 1'b0);
      goto_cyc(cyc + 2);

      // prog0: one tone then END
      pulse_start(2'd0, l);
      push_prog0(l, 1'b1);
      goto_cyc(l + 40);

      // prog1: tone, rest, tone, END
      pulse_start(2'd1, l);
      push_prog1_head(l);
      push_prog1_tail(l);
      goto_cyc(l + 62);

      // prog2: last note at top of ROM, no END marker
      pulse_start(2'd2, l);
      push(l,      3'b100);
      push(l + 5,  3'b101);
      push(l + 9,  3'b100);
      push(l + 20, 3'b101);
      push(l + 22, 3'b010);
      push(l + 23, 3'b000);
      goto_cyc(l + 40);

      // prog1 preempts prog0 mid-tone; no DONE for prog0
      pulse_start(2'd0, l);
      l2 = l + 12;
      push(l,     3'b100);
      push(l + 9, 3'b101);
      push(l2,    3'b100);
      push(l2 + 5, 3'b101);
      push(l2 + 9, 3'b100);
      push_prog1_tail(l2);
      goto_cyc(l + 11);
      pulse_start(2'd1, t);
      goto_cyc(l2 + 62);

      // lower-index START during prog1 rest
      pulse_start(2'd1, l);
      push_prog1_head(l);
`ifdef TONE_SEQ_PRIORITY_EN
      push_prog1_tail(l);
`else
      push_prog0(l + 21, 1'b0);
`endif
      goto_cyc(l + 20);
      pulse_start(2'd0, t);
      goto_cyc(l + 80);

      // START and ABORT together while idle
      START    = 1'b1;
      ABORT    = 1'b1;
      PROG_SEL = 2'd0;
      t        = cyc;
      goto_cyc(t + 1);
      check("abort_idle_busy1", BUSY, 1'b0);
      goto_cyc(t + 3);
      check("abort_idle_busy3", BUSY, 1'b0);
      check("abort_idle_audio", AUDIO, 1'b0);

      // ABORT during PLAY while audio is high
      pulse_start(2'd0, l);
      push(l,      3'b100);
      push(l + 9,  3'b101);
      push(l + 13, 3'b000);
      goto_cyc(l + 12);
      ABORT = 1'b1;
      goto_cyc(l + 20);

      // async reset mid-PLAY
      pulse_start(2'd0, l);
      push(l,      3'b100);
      push(l + 9,  3'b101);
      push(l + 11, 3'b000);
      goto_cyc(l + 10);
      #2 RESET_N = 1'b0;
      #1;
      check("async_rst_audio", AUDIO, 1'b0);
      check("async_rst_busy", BUSY, 1'b0);
      check("async_rst_done", DONE, 1'b0);
      goto_cyc(cyc + 2);
      #2 RESET_N = 1'b1;
      goto_cyc(cyc + 10);
      check("post_rst_idle", BUSY, 1'b0);

      goto_cyc(cyc + 5);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL sb_left got=%0d want=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
